// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: locks to an hsync/vsync pair, recovers column/line/de and flags timing deviations
module vga_timing_monitor #(
  parameter int HVA = 640,
  parameter int HSP = 96,
  parameter int HBP = 48,
  parameter int HWL = 800,
  parameter int VVA = 480,
  parameter int VSP = 2,
  parameter int VBP = 33,
  parameter int VWF = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        err_clr,
  output logic [11:0] column,
  output logic [11:0] line,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic [3:0]  err
);
  localparam logic [1:0] SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2;
  localparam int HS = HSP + HBP;
  localparam int VS = VSP + VBP;
  logic [1:0] state, state_nx;
  logic [7:0] good_cnt, good_nx, good_inc;
  logic [11:0] hcnt, vcnt, hlow, vlow;
  logic [12:0] hcnt_inc, vcnt_inc;
  logic h_q, v_q, h_chk, v_chk, fdirty, fs_q;
  logic h_fall, h_rise, v_fall, v_rise, tmo, clean, de_nx;
  logic [3:0] ev, e_q;
  always_comb begin
    h_fall = h_q & ~hsync;
    h_rise = ~h_q & hsync;
    v_fall = v_q & ~vsync;
    v_rise = ~v_q & vsync;
    hcnt_inc = {1'b0, hcnt} + 13'd1;
    vcnt_inc = {1'b0, vcnt} + 13'd1;
    tmo = ~h_fall & (hcnt_inc == 13'(2 * HWL));
    ev = {v_rise & (vlow != 12'(VSP)),
          v_fall & v_chk & (vcnt_inc != 13'(VWF)),
          h_rise & (hlow != 12'(HSP)),
          (h_fall & h_chk & (hcnt_inc != 13'(HWL))) | tmo};
    clean = ~fdirty & ~|ev;
    good_inc = good_cnt + 8'd1;
    state_nx = state;
    good_nx = good_cnt;
    if (tmo) begin
      state_nx = SEARCH;
      good_nx = '0;
    end else if (state == SEARCH) begin
      state_nx = v_fall ? MEASURE : SEARCH;
      good_nx = '0;
    end else if (state == LOCKED) begin
      state_nx = |ev ? MEASURE : LOCKED;
      good_nx = |ev ? '0 : good_cnt;
    end else if (v_fall) begin
      good_nx = clean ? good_inc : '0;
      state_nx = (clean && good_inc == 8'(LOCK_FRAMES)) ? LOCKED : MEASURE;
    end
    de_nx = (state == LOCKED) && hcnt >= 12'(HS) && hcnt < 12'(HS + HVA) &&
            vcnt >= 12'(VS) && vcnt < 12'(VS + VVA);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEARCH;
      good_cnt <= '0;
      hcnt <= '0;
      vcnt <= '0;
      hlow <= '0;
      vlow <= '0;
      h_q <= 1'b1;
      v_q <= 1'b1;
      h_chk <= 1'b0;
      v_chk <= 1'b0;
      fdirty <= 1'b0;
      fs_q <= 1'b0;
      e_q <= '0;
      column <= '0;
      line <= '0;
      de <= 1'b0;
      frame_start <= 1'b0;
      locked <= 1'b0;
      err <= '0;
    end else begin
      if (en) begin
        h_q <= hsync;
        v_q <= vsync;
        hcnt <= h_fall ? '0 : (hcnt == 12'hfff ? hcnt : hcnt + 12'd1);
        hlow <= h_fall ? 12'd1 : ((~hsync && hlow != 12'hfff) ? hlow + 12'd1 : hlow);
        vcnt <= v_fall ? '0 : ((h_fall && vcnt != 12'hfff) ? vcnt + 12'd1 : vcnt);
        vlow <= v_fall ? {11'd0, h_fall} : ((h_fall && ~vsync && vlow != 12'hfff) ? vlow + 12'd1 : vlow);
        h_chk <= tmo ? 1'b0 : (h_fall | h_chk);
        v_chk <= tmo ? 1'b0 : (v_fall | v_chk);
        fdirty <= v_fall ? 1'b0 : (fdirty | |ev);
        state <= state_nx;
        good_cnt <= good_nx;
      end
      // errors seen while searching are ignored; they only matter once a lock attempt is running
      e_q <= (en && state != SEARCH) ? ev : '0;
      fs_q <= en & v_fall & (state == LOCKED);
      err <= (err_clr ? 4'd0 : err) | e_q;
      frame_start <= fs_q;
      locked <= state == LOCKED;
      de <= de_nx;
      column <= de_nx ? hcnt - 12'(HS) : '0;
      line <= de_nx ? vcnt - 12'(VS) : '0;
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: scaled-down timing stream against a timestamp-based reference model
module tb_vga_timing_monitor;
  localparam int HVA = 8, HSP = 3, HBP = 2, HWL = 16;
  localparam int VVA = 4, VSP = 2, VBP = 1, VWF = 9, LF = 2;
  localparam int HS = HSP + HBP, VS = VSP + VBP;
  logic clk = 0, rst, en, hsync, vsync, err_clr;
  logic [11:0] column, line;
  logic de, frame_start, locked;
  logic [3:0] err;
  int checks = 0, errors = 0;
  bit chk_on = 0, tog = 0;
  vga_timing_monitor #(.HVA(HVA), .HSP(HSP), .HBP(HBP), .HWL(HWL), .VVA(VVA), .VSP(VSP),
    .VBP(VBP), .VWF(VWF), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .en(en), .hsync(hsync), .vsync(vsync), .err_clr(err_clr),
    .column(column), .line(line), .de(de), .frame_start(frame_start), .locked(locked), .err(err));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // reference model: sync intervals measured as differences of en-sample timestamps
  int n, t_hf, hfc, hf_vf, hf_bvf, hc, vc, mst, good;
  bit mhq, mvq, hchk, vchk, dirty, hf, hr, vf, vr, to, fsq;
  logic [3:0] e, evq, x_err;
  logic [11:0] x_col, x_line;
  logic x_de, x_fs, x_lock;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n = 0; t_hf = 0; hfc = 0; hf_vf = 0; hf_bvf = 0; mhq = 1; mvq = 1;
      hchk = 0; vchk = 0; dirty = 0; mst = 0; good = 0; fsq = 0; evq = 0;
      x_col = 0; x_line = 0; x_de = 0; x_fs = 0; x_lock = 0; x_err = 0;
    end else begin
      hc = (n - t_hf > 4095) ? 4095 : n - t_hf;
      vc = (hfc - hf_vf > 4095) ? 4095 : hfc - hf_vf;
      x_lock = mst == 2;
      x_de = x_lock && hc >= HS && hc < HS + HVA && vc >= VS && vc < VS + VVA;
      x_col = x_de ? 12'(hc - HS) : 12'd0;
      x_line = x_de ? 12'(vc - VS) : 12'd0;
      x_fs = fsq;
      x_err = (err_clr ? 4'd0 : x_err) | evq;
      fsq = 0; evq = 0;
      if (en) begin
        hf = mhq && !hsync; hr = !mhq && hsync; vf = mvq && !vsync; vr = !mvq && vsync;
        n++;
        e = 0;
        if (hr && n - t_hf != HSP) e[1] = 1;
        if (vr && hfc - hf_bvf != VSP) e[3] = 1;
        if (vf && vchk && hfc - hf_vf + 1 != VWF) e[2] = 1;
        if (hf && hchk && n - t_hf != HWL) e[0] = 1;
        to = !hf && n - t_hf == 2 * HWL;
        if (to) e[0] = 1;
        if (vf) hf_bvf = hfc;
        if (hf) begin t_hf = n; hfc++; end
        if (vf) hf_vf = hfc;
        evq = (mst == 0) ? 4'd0 : e;
        fsq = vf && mst == 2;
        if (to) begin mst = 0; good = 0; end
        else if (mst == 0) begin if (vf) mst = 1; good = 0; end
        else if (mst == 2) begin if (|e) begin mst = 1; good = 0; end end
        else if (vf) begin
          if (!dirty && e == 0) begin good++; if (good == LF) mst = 2; end
          else good = 0;
        end
        dirty = vf ? 0 : (dirty || e != 0);
        hchk = to ? 0 : (hf || hchk);
        vchk = to ? 0 : (vf || vchk);
        mhq = hsync; mvq = vsync;
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("column", column, x_col);
    chk("line", line, x_line);
    chk("de", de, x_de);
    chk("frame_start", frame_start, x_fs);
    chk("locked", locked, x_lock);
    chk("err", err, x_err);
  end
  task automatic step(input bit e_, input bit h, input bit v);
    @(negedge clk);
    en = e_; hsync = h; vsync = v;
  endtask
  task automatic px(input bit h, input bit v);
    if (tog) step(0, h, v);
    step(1, h, v);
  endtask
  task automatic pause;
    step(0, hsync, vsync);
    @(negedge clk);
  endtask
  task automatic clr;
    @(negedge clk); en = 0; err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_clr", err, 0);
  endtask
  typedef struct {int l; int p; int d; int c; int y;} pt_t;
  pt_t pts[8] = '{'{0, 0, 0, 0, 0}, '{2, 5, 0, 0, 0}, '{3, 4, 0, 0, 0}, '{3, 5, 1, 0, 0},
                  '{3, 12, 1, 7, 0}, '{3, 13, 0, 0, 0}, '{6, 5, 1, 0, 3}, '{7, 5, 0, 0, 0}};
  task automatic frame(input int nl = VWF, input int vsw = VSP, input int bl = -1,
                       input int blen = HWL, input int bhw = HSP, input int mode = 0);
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < (l == bl ? blen : HWL); p++) begin
        px(p >= (l == bl ? bhw : HSP), l >= vsw);
        if (mode == 1)
          foreach (pts[i]) if (pts[i].l == l && pts[i].p == p) begin
            pause;
            chk("pt_de", de, pts[i].d);
            chk("pt_column", column, pts[i].c);
            chk("pt_line", line, pts[i].y);
            if (l == 0) chk("pt_fs_locked", {frame_start, locked}, 2'b11);
          end
        if (mode == 2 && l == 4 && p == 8)
          for (int i = 0; i < 100; i++) begin
            step(0, hsync, vsync);
            if (i % 25 == 24) chk("freeze", {de, column, line}, {1'b1, 12'd3, 12'd1});
          end
        if (mode == 3 && l == 4 && p == 6) begin
          @(negedge clk); #2 rst = 0;
          #1 chk("rst_async", {column, line, de, frame_start, locked, err}, 0);
          @(negedge clk); #2 rst = 1;
        end
      end
  endtask
  initial begin
    rst = 0; en = 0; hsync = 1; vsync = 1; err_clr = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("reset_outputs", {column, line, de, frame_start, locked, err}, 0);
    rst = 1;
    tog = 1;
    frame(); frame(); pause;
    chk("no_lock_2_frames", locked, 0);
    frame(); pause;
    chk("lock_3rd_vfall", locked, 1);
    frame(); pause;
    chk("err_nominal", err, 0);
    tog = 0;
    frame(.mode(1));
    frame(.bl(4), .blen(HWL + 1)); pause;
    chk("hperiod_err", {err, locked}, {4'b0001, 1'b0});
    frame(); frame(); pause;
    chk("relock_pending", locked, 0);
    frame(); pause;
    chk("relocked", {err, locked}, {4'b0001, 1'b1});
    clr;
    frame(.bl(4), .bhw(HSP - 1)); pause;
    chk("hwidth_err", err, 4'b0010);
    clr;
    frame(.vsw(VSP + 1)); pause;
    chk("vwidth_err", err, 4'b1000);
    clr;
    frame(.nl(VWF - 1)); frame(); pause;
    chk("vperiod_err", err, 4'b0100);
    clr;
    repeat (2 * HWL + 8) px(1, 1);
    pause;
    chk("stuck_h", {err, locked, de}, {4'b0001, 1'b0, 1'b0});
    frame(); frame(); frame(); pause;
    chk("relock_after_search", locked, 1);
    frame(.mode(2)); pause;
    chk("freeze_no_err", err, 4'b0001);
    frame(.mode(3)); frame(); frame(); pause;
    chk("post_rst_no_lock", locked, 0);
    frame(); pause;
    chk("post_rst_lock", {err, locked}, {4'b0000, 1'b1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
